target_hit_tracker: RTL and testbench

Consumer side of the playfield target-position interface. Takes the six fixed target coordinates (two red circles, two green circles, two purple hexagons) and the ball position. Once per video frame it scans every live target for a collision, retires hit targets, and accumulates score. When the board is cleared it runs a reload handshake with the target-placement logic and re-arms all six targets.

---
 rtl/target_hit_tracker.sv | 246 ++++++++++++++++++++++++
 tb/tb_target_hit_tracker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_hit_tracker.sv
// Frame-rate collision scanner for the six playfield targets: retires hit targets,
// accumulates a saturating score and re-arms the board through a reload handshake.
// Optional build macro: HIT_COMBO_EN (double points inside a combo window).
module target_hit_tracker #(
    parameter int unsigned HIT_RADIUS    = 16,
    parameter int unsigned RED_POINTS    = 10,
    parameter int unsigned GREEN_POINTS  = 20,
    parameter int unsigned PURPLE_POINTS = 50
`ifdef HIT_COMBO_EN
    ,
    parameter int unsigned COMBO_WINDOW  = 60
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    input  logic [11:0] red_circle_a_x,
    input  logic [11:0] red_circle_a_y,
    input  logic [11:0] red_circle_b_x,
    input  logic [11:0] red_circle_b_y,
    input  logic [11:0] green_circle_a_x,
    input  logic [11:0] green_circle_a_y,
    input  logic [11:0] green_circle_b_x,
    input  logic [11:0] green_circle_b_y,
    input  logic [11:0] purple_hexagon_a_x,
    input  logic [11:0] purple_hexagon_a_y,
    input  logic [11:0] purple_hexagon_b_x,
    input  logic [11:0] purple_hexagon_b_y,
    input  logic        reload_ack,
    output logic [5:0]  target_alive,
    output logic [15:0] score,
    output logic        hit_pulse,
    output logic [2:0]  hit_index,
    output logic        all_cleared,
    output logic        reload_req,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_CMP    = 3'd2,
        S_NEXT   = 3'd3,
        S_RELOAD = 3'd4
    } state_t;

    localparam logic [24:0] RADIUS_SQ  = 25'(HIT_RADIUS * HIT_RADIUS);
    localparam logic [15:0] RED_PTS    = 16'(RED_POINTS);
    localparam logic [15:0] GREEN_PTS  = 16'(GREEN_POINTS);
    localparam logic [15:0] PURPLE_PTS = 16'(PURPLE_POINTS);

    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] bx_q, bx_d, by_q, by_d;
    logic [11:0] adx_q, adx_d, ady_q, ady_d;
    logic [5:0]  alive_q, alive_d;
    logic [15:0] score_q, score_d;
    logic        pulse_q, pulse_d;
    logic [2:0]  hidx_q, hidx_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;

    logic [11:0] tx_s, ty_s;
    logic [23:0] sqx_s, sqy_s;
    logic [24:0] d2_s;
    logic        hit_s;
    logic        reload_done_s;
    logic [15:0] points_s;
    logic [16:0] add_s;
    logic [16:0] sum_s;
    logic [15:0] sat_s;

    // Live target coordinate and colour value for the index under test.
    always_comb begin
        tx_s     = 12'd0;
        ty_s     = 12'd0;
        points_s = 16'd0;
        case (idx_q)
            3'd0: begin tx_s = red_circle_a_x;     ty_s = red_circle_a_y;     points_s = RED_PTS;    end
            3'd1: begin tx_s = red_circle_b_x;     ty_s = red_circle_b_y;     points_s = RED_PTS;    end
            3'd2: begin tx_s = green_circle_a_x;   ty_s = green_circle_a_y;   points_s = GREEN_PTS;  end
            3'd3: begin tx_s = green_circle_b_x;   ty_s = green_circle_b_y;   points_s = GREEN_PTS;  end
            3'd4: begin tx_s = purple_hexagon_a_x; ty_s = purple_hexagon_a_y; points_s = PURPLE_PTS; end
            3'd5: begin tx_s = purple_hexagon_b_x; ty_s = purple_hexagon_b_y; points_s = PURPLE_PTS; end
            default: begin tx_s = 12'd0; ty_s = 12'd0; points_s = 16'd0; end
        endcase
    end

    // Full-width squared distance so far-away targets can never alias into a hit.
    assign sqx_s         = {12'd0, adx_q} * {12'd0, adx_q};
    assign sqy_s         = {12'd0, ady_q} * {12'd0, ady_q};
    assign d2_s          = {1'b0, sqx_s} + {1'b0, sqy_s};
    assign hit_s         = (state_q == S_CMP) && alive_q[idx_q] && (d2_s <= RADIUS_SQ);
    assign reload_done_s = (state_q == S_RELOAD) && reload_ack;

`ifdef HIT_COMBO_EN
    localparam logic [15:0] COMBO_MAX = 16'(COMBO_WINDOW);
    logic [15:0] combo_cnt_q, combo_cnt_d;

    // Combo window restarts on every hit, advances once per frame and closes at COMBO_MAX.
    always_comb begin
        combo_cnt_d = combo_cnt_q;
        if (hit_s) begin
            combo_cnt_d = 16'd0;
        end else if (reload_done_s) begin
            combo_cnt_d = COMBO_MAX;
        end else if (frame_tick && (combo_cnt_q < COMBO_MAX)) begin
            combo_cnt_d = combo_cnt_q + 16'd1;
        end else begin
            combo_cnt_d = combo_cnt_q;
        end
    end

    // Combo counter register; reset leaves the window closed.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_cnt_q <= COMBO_MAX;
        end else begin
            combo_cnt_q <= combo_cnt_d;
        end
    end

    assign add_s = (combo_cnt_q < COMBO_MAX) ? {points_s, 1'b0} : {1'b0, points_s};
`else
    assign add_s = {1'b0, points_s};
`endif

    assign sum_s = {1'b0, score_q} + add_s;
    assign sat_s = sum_s[16] ? 16'hFFFF : sum_s[15:0];

    // Scan sequencer: next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bx_d    = bx_q;
        by_d    = by_q;
        adx_d   = adx_q;
        ady_d   = ady_q;
        alive_d = alive_q;
        score_d = score_q;
        pulse_d = 1'b0;
        hidx_d  = hidx_q;
        req_d   = req_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    bx_d    = ball_x;
                    by_d    = ball_y;
                    idx_d   = 3'd0;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                adx_d   = abs_diff(bx_q, tx_s);
                ady_d   = abs_diff(by_q, ty_s);
                state_d = S_CMP;
            end
            S_CMP: begin
                if (hit_s) begin
                    alive_d[idx_q] = 1'b0;
                    pulse_d        = 1'b1;
                    hidx_d         = idx_q;
                    score_d        = sat_s;
                end else begin
                    score_d = score_q;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == 3'd5) begin
                    if (alive_q == 6'd0) begin
                        req_d   = 1'b1;
                        state_d = S_RELOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d   = 3'(idx_q + 3'd1);
                    state_d = S_CALC;
                end
            end
            S_RELOAD: begin
                if (reload_ack) begin
                    alive_d = 6'b111111;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    req_d   = 1'b1;
                    state_d = S_RELOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            bx_q    <= 12'd0;
            by_q    <= 12'd0;
            adx_q   <= 12'd0;
            ady_q   <= 12'd0;
            alive_q <= 6'b111111;
            score_q <= 16'd0;
            pulse_q <= 1'b0;
            hidx_q  <= 3'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            adx_q   <= adx_d;
            ady_q   <= ady_d;
            alive_q <= alive_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
            hidx_q  <= hidx_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    assign target_alive = alive_q;
    assign score        = score_q;
    assign hit_pulse    = pulse_q;
    assign hit_index    = hidx_q;
    assign reload_req   = req_q;
    assign busy         = busy_q;
    assign all_cleared  = (alive_q == 6'd0);

endmodule

// File: tb/tb_target_hit_tracker.sv
// Directed self-checking bench for target_hit_tracker (default build, no combo).
module tb_target_hit_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        reload_ack;
    logic [11:0] ball_x, ball_y;
    logic [11:0] tx [6];
    logic [11:0] ty [6];
    logic [5:0]  target_alive;
    logic [15:0] score;
    logic        hit_pulse;
    logic [2:0]  hit_index;
    logic        all_cleared;
    logic        reload_req;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    target_hit_tracker dut (
        .clk                (clk),
        .rst                (rst),
        .frame_tick         (frame_tick),
        .ball_x             (ball_x),
        .ball_y             (ball_y),
        .red_circle_a_x     (tx[0]),
        .red_circle_a_y     (ty[0]),
        .red_circle_b_x     (tx[1]),
        .red_circle_b_y     (ty[1]),
        .green_circle_a_x   (tx[2]),
        .green_circle_a_y   (ty[2]),
        .green_circle_b_x   (tx[3]),
        .green_circle_b_y   (ty[3]),
        .purple_hexagon_a_x (tx[4]),
        .purple_hexagon_a_y (ty[4]),
        .purple_hexagon_b_x (tx[5]),
        .purple_hexagon_b_y (ty[5]),
        .reload_ack         (reload_ack),
        .target_alive       (target_alive),
        .score              (score),
        .hit_pulse          (hit_pulse),
        .hit_index          (hit_index),
        .all_cleared        (all_cleared),
        .reload_req         (reload_req),
        .busy               (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic park_all();
        for (int i = 0; i < 6; i++) begin
            tx[i] = 12'd3000;
            ty[i] = 12'd3000;
        end
    endtask

    task automatic all_at(input logic [11:0] x, input logic [11:0] y);
        for (int i = 0; i < 6; i++) begin
            tx[i] = x;
            ty[i] = y;
        end
    endtask

    task automatic run_scan(output int pulses);
        pulses = 0;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (hit_pulse === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (target_alive !== 6'b111111) begin errors++; $display("FAIL reset_alive: got %b expected %b", target_alive, 6'b111111); end
        checks++;
        if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++;
        if (hit_pulse !== 1'b0 || hit_index !== 3'd0) begin errors++; $display("FAIL reset_hit: got pulse %b index %0d expected 0/0", hit_pulse, hit_index); end
        checks++;
        if (reload_req !== 1'b0 || busy !== 1'b0 || all_cleared !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got req %b busy %b clr %b expected 0/0/0", reload_req, busy, all_cleared); end
        rst = 1'b0;
    endtask

    task automatic test_direct_hit();
        logic exp_pulse;
        apply_reset();
        park_all();
        tx[0] = 12'd240; ty[0] = 12'd100;
        ball_x = 12'd240; ball_y = 12'd100;
        do_tick();
        for (int c = 1; c <= 18; c++) begin
            step();
            exp_pulse = (c == 2);
            checks++;
            if (hit_pulse !== exp_pulse) begin errors++; $display("FAIL direct_pulse c%0d: got %b expected %b", c, hit_pulse, exp_pulse); end
            if (c == 2) begin
                checks++;
                if (hit_index !== 3'd0) begin errors++; $display("FAIL direct_index: got %0d expected 0", hit_index); end
                checks++;
                if (target_alive !== 6'b111110) begin errors++; $display("FAIL direct_alive: got %b expected 111110", target_alive); end
                checks++;
                if (score !== 16'd10) begin errors++; $display("FAIL direct_score: got %0d expected 10", score); end
            end
            if (c == 18) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL direct_idle: got busy %b expected 0", busy); end
            end
        end
    endtask

    task automatic test_radius_boundary();
        int p;
        apply_reset();
        park_all();
        tx[0] = 12'd240; ty[0] = 12'd100;
        ball_x = 12'd257; ball_y = 12'd100;
        do_tick();
        run_scan(p);
        checks++;
        if (p != 0 || score !== 16'd0 || target_alive !== 6'b111111) begin errors++; $display("FAIL radius_outside: got pulses %0d score %0d alive %b expected 0/0/111111", p, score, target_alive); end
        ball_x = 12'd256;
        do_tick();
        run_scan(p);
        checks++;
        if (p != 1 || score !== 16'd10 || target_alive !== 6'b111110) begin errors++; $display("FAIL radius_edge: got pulses %0d score %0d alive %b expected 1/10/111110", p, score, target_alive); end
        tx[1] = 12'd240; ty[1] = 12'd100;
        ball_x = 12'd240; ball_y = 12'd84;
        do_tick();
        run_scan(p);
        checks++;
        if (p != 1 || score !== 16'd20 || target_alive !== 6'b111100 || hit_index !== 3'd1) begin errors++; $display("FAIL radius_neg_dy: got pulses %0d score %0d alive %b idx %0d expected 1/20/111100/1", p, score, target_alive, hit_index); end
    endtask

    task automatic test_multi_hit();
        logic exp_pulse;
        apply_reset();
        park_all();
        tx[4] = 12'd320; ty[4] = 12'd150;
        tx[3] = 12'd330; ty[3] = 12'd150;
        ball_x = 12'd320; ball_y = 12'd150;
        do_tick();
        for (int c = 1; c <= 19; c++) begin
            if (c == 1) begin ball_x = 12'd0; ball_y = 12'd0; end
            frame_tick = (c == 6);
            step();
            frame_tick = 1'b0;
            exp_pulse = (c == 11) || (c == 14);
            checks++;
            if (hit_pulse !== exp_pulse) begin errors++; $display("FAIL multi_pulse c%0d: got %b expected %b", c, hit_pulse, exp_pulse); end
            if (c == 11) begin
                checks++;
                if (hit_index !== 3'd3 || score !== 16'd20) begin errors++; $display("FAIL multi_first: got idx %0d score %0d expected 3/20", hit_index, score); end
            end
            if (c == 14) begin
                checks++;
                if (hit_index !== 3'd4 || score !== 16'd70 || target_alive !== 6'b100111) begin errors++; $display("FAIL multi_second: got idx %0d score %0d alive %b expected 4/70/100111", hit_index, score, target_alive); end
            end
            if (c >= 18) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL multi_idle c%0d: got busy %b expected 0", c, busy); end
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        all_at(12'd500, 12'd500);
        ball_x = 12'd500; ball_y = 12'd500;
        for (int b = 0; b < 409; b++) begin
            do_tick();
            repeat (18) step();
            checks++;
            if (reload_req !== 1'b1) begin errors++; $display("FAIL sat_board_req b%0d: got %b expected 1", b, reload_req); end
            reload_ack = 1'b1;
            step();
            reload_ack = 1'b0;
        end
        checks++;
        if (score !== 16'd65440 || target_alive !== 6'b111111) begin errors++; $display("FAIL sat_preload: got score %0d alive %b expected 65440/111111", score, target_alive); end
        tx[3] = 12'd3000; ty[3] = 12'd3000;
        do_tick();
        for (int c = 1; c <= 18; c++) begin
            step();
            if (c == 14) begin
                checks++;
                if (score !== 16'd65530) begin errors++; $display("FAIL sat_pre_purple: got %0d expected 65530", score); end
            end
            if (c == 17) begin
                checks++;
                if (score !== 16'hFFFF || hit_pulse !== 1'b1 || hit_index !== 3'd5) begin errors++; $display("FAIL sat_clamp: got score %0d pulse %b idx %0d expected 65535/1/5", score, hit_pulse, hit_index); end
            end
            if (c == 18) begin
                checks++;
                if (target_alive !== 6'b001000 || busy !== 1'b0) begin errors++; $display("FAIL sat_end: got alive %b busy %b expected 001000/0", target_alive, busy); end
            end
        end
    endtask

    task automatic test_clear_reload();
        apply_reset();
        all_at(12'd500, 12'd500);
        ball_x = 12'd500; ball_y = 12'd500;
        do_tick();
        repeat (18) step();
        checks++;
        if (all_cleared !== 1'b1 || reload_req !== 1'b1 || busy !== 1'b1 || score !== 16'd160) begin errors++; $display("FAIL clear_state: got clr %b req %b busy %b score %0d expected 1/1/1/160", all_cleared, reload_req, busy, score); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (reload_req !== 1'b1 || target_alive !== 6'd0) begin errors++; $display("FAIL clear_hold c%0d: got req %b alive %b expected 1/000000", c, reload_req, target_alive); end
        end
        reload_ack = 1'b1;
        step();
        reload_ack = 1'b0;
        checks++;
        if (target_alive !== 6'b111111 || reload_req !== 1'b0 || busy !== 1'b0 || all_cleared !== 1'b0) begin errors++; $display("FAIL reload_done: got alive %b req %b busy %b clr %b expected 111111/0/0/0", target_alive, reload_req, busy, all_cleared); end
        checks++;
        if (score !== 16'd160) begin errors++; $display("FAIL reload_score: got %0d expected 160", score); end
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        all_at(12'd500, 12'd500);
        ball_x = 12'd500; ball_y = 12'd500;
        do_tick();
        repeat (5) step();
        checks++;
        if (score !== 16'd20) begin errors++; $display("FAIL midrst_pre: got %0d expected 20", score); end
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (score !== 16'd0 || target_alive !== 6'b111111 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state: got score %0d alive %b busy %b expected 0/111111/0", score, target_alive, busy); end
        checks++;
        if (hit_pulse !== 1'b0 || hit_index !== 3'd0 || reload_req !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got pulse %b idx %0d req %b expected 0/0/0", hit_pulse, hit_index, reload_req); end
        step();
        checks++;
        if (hit_pulse !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after: got pulse %b busy %b expected 0/0", hit_pulse, busy); end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        reload_ack = 1'b0;
        ball_x     = 12'd0;
        ball_y     = 12'd0;
        park_all();
        test_reset();
        test_direct_hit();
        test_radius_boundary();
        test_multi_hit();
        test_saturation();
        test_clear_reload();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
